// File: rtl/pc_pkg.sv
// Shared definitions for the KGPminiRISC fetch-stage PC sequencer:
// redirect-kind encoding, default instruction size and a constant log2 helper.
package pc_pkg;

  typedef enum logic [1:0] {
    KIND_JUMP = 2'd0,
    KIND_CALL = 2'd1,
    KIND_RET  = 2'd2,
    KIND_RSVD = 2'd3
  } redir_kind_e;

  localparam int DEFAULT_INSTR_BYTES = 4;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int pc_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on an empty stack are flagged instead of performed.
module ras_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam int PW = pc_log2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]     tos_q, tos_d, wr_ptr;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign ovf_o   = ovf_q;
  assign unf_o   = pop_i & empty_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wr_ptr  = tos_q + PW'(1);
  assign top_o   = mem_q[tos_q];

  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      tos_d = wr_ptr;
      if (full_o) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      tos_d = tos_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; count == 0 guarantees no stale
  // entry is ever selected, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance, stall hold, and
// JUMP/CALL/RET redirects backed by a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              misalign
);

  localparam int                AL       = pc_log2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ~({ADDR_W{1'b1}} << AL);
  localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] raw_target;
  logic              is_call, is_ret;
  logic              ras_unf_c;
  logic              ras_unf_q, ras_unf_d;
  logic              misalign_q, misalign_d;

  assign is_call = redir_valid && (redir_kind == KIND_CALL);
  assign is_ret  = redir_valid && (redir_kind == KIND_RET);

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (is_call),
    .pop_i      (is_ret),
    .push_data_i(link_addr),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .ovf_o      (ras_ovf),
    .unf_o      (ras_unf_c)
  );

  // Redirect beats stall so a flush is never lost behind a frozen pipeline.
  always_comb begin
    raw_target = redir_target;
    if (is_ret && !ras_empty) raw_target = ras_top;

    if (redir_valid)  pc_next = raw_target & ~LOW_MASK;
    else if (stall)   pc_next = pc_q;
    else              pc_next = pc_q + INCR;

    misalign_d = redir_valid && ((raw_target & LOW_MASK) != '0);
    ras_unf_d  = ras_unf_c;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      ras_unf_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_next;
      ras_unf_q  <= ras_unf_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign ras_unf  = ras_unf_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_kind = 2'd0;
  logic [31:0] redir_target = '0;
  logic [31:0] link_addr = '0;
  logic [31:0] pc, pc_next;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_target(redir_target),
    .link_addr   (link_addr),
    .pc          (pc),
    .pc_next     (pc_next),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic [4:0]  flags;  // {empty, full, ovf, unf, misalign}
  } exp_t;

  exp_t        sb[$];
  int unsigned cycle_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sb.size() > 0 && sb[0].cyc == cycle_cnt) begin
      exp_t e;
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("flags", {27'd0, ras_empty, ras_full, ras_ovf, ras_unf, misalign}, {27'd0, e.flags});
      if (sb.size() > 0 && sb[0].cyc == cycle_cnt + 1)
        check("pc_next", pc_next, sb[0].pc);
    end
  end

  // One clock of stimulus plus the state expected right after that edge.
  task automatic cyc(input logic st, input logic rv, input logic [1:0] kind,
                     input logic [31:0] tgt, input logic [31:0] link,
                     input logic [31:0] exp_pc, input logic [4:0] exp_flags);
    exp_t e;
    stall        = st;
    redir_valid  = rv;
    redir_kind   = kind;
    redir_target = tgt;
    link_addr    = link;
    e.cyc   = cycle_cnt + 1;
    e.pc    = exp_pc;
    e.flags = exp_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_kind  = KIND_JUMP;
  endtask

  task automatic idle(input logic [31:0] exp_pc, input logic [4:0] exp_flags);
    cyc(1'b0, 1'b0, KIND_JUMP, 32'h0, 32'h0, exp_pc, exp_flags);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1'b1;
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_pc_next", pc_next, 32'h4);
    check("reset_flags", {27'd0, ras_empty, ras_full, ras_ovf, ras_unf, misalign}, 32'b10000);

    // Free run and stall; redirect overrides stall.
    idle(32'h4, 5'b10000);
    idle(32'h8, 5'b10000);
    idle(32'hC, 5'b10000);
    idle(32'h10, 5'b10000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, KIND_JUMP, 32'h0, 32'h0, 32'h10, 5'b10000);
    cyc(1'b1, 1'b1, KIND_JUMP, 32'h200, 32'h0, 32'h200, 5'b10000);

    // CALL then immediate RET returns the just-pushed link.
    cyc(1'b0, 1'b1, KIND_CALL, 32'h100, 32'h24, 32'h100, 5'b00000);
    cyc(1'b0, 1'b1, KIND_RET,  32'h500, 32'h0,  32'h24,  5'b10000);

    // Overflow: five CALLs into a four-entry stack, then five RETs.
    cyc(1'b0, 1'b1, KIND_CALL, 32'h400, 32'hA0, 32'h400, 5'b00000);
    cyc(1'b0, 1'b1, KIND_CALL, 32'h410, 32'hB0, 32'h410, 5'b00000);
    cyc(1'b0, 1'b1, KIND_CALL, 32'h420, 32'hC0, 32'h420, 5'b00000);
    cyc(1'b0, 1'b1, KIND_CALL, 32'h430, 32'hD0, 32'h430, 5'b01000);
    cyc(1'b0, 1'b1, KIND_CALL, 32'h440, 32'hE0, 32'h440, 5'b01100);
    cyc(1'b0, 1'b1, KIND_RET,  32'h300, 32'h0,  32'hE0,  5'b00100);
    cyc(1'b0, 1'b1, KIND_RET,  32'h300, 32'h0,  32'hD0,  5'b00100);
    cyc(1'b0, 1'b1, KIND_RET,  32'h300, 32'h0,  32'hC0,  5'b00100);
    cyc(1'b0, 1'b1, KIND_RET,  32'h300, 32'h0,  32'hB0,  5'b10100);
    cyc(1'b0, 1'b1, KIND_RET,  32'h300, 32'h0,  32'h300, 5'b10110);
    idle(32'h304, 5'b10100);

    // Misaligned target, reserved kind, and address wrap.
    cyc(1'b0, 1'b1, KIND_JUMP, 32'h203, 32'h0, 32'h200, 5'b10101);
    idle(32'h204, 5'b10100);
    cyc(1'b0, 1'b1, KIND_RSVD, 32'h208, 32'h0, 32'h208, 5'b10100);
    cyc(1'b0, 1'b1, KIND_JUMP, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 5'b10100);
    idle(32'h0, 5'b10100);
    idle(32'h4, 5'b10100);

    // Build count = 2; a stall with a RET kind but no redirect must not pop.
    cyc(1'b0, 1'b1, KIND_CALL, 32'h600, 32'h50, 32'h600, 5'b00100);
    cyc(1'b1, 1'b0, KIND_RET,  32'h0,   32'h0,  32'h600, 5'b00100);
    cyc(1'b0, 1'b1, KIND_CALL, 32'h610, 32'h54, 32'h610, 5'b00100);

    // Asynchronous reset mid-cycle discards the stack.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_pc_next", pc_next, 32'h4);
    check("midrst_flags", {27'd0, ras_empty, ras_full, ras_ovf, ras_unf, misalign}, 32'b10000);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b1, KIND_RET, 32'h40, 32'h0, 32'h40, 5'b10010);
    idle(32'h44, 5'b10000);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never compared", sb.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the KGPminiRISC fetch stage. It holds the architectural PC and advances it sequentially, freezes it under stall, and redirects it on branch/jump, call and return. An internal circular return-address stack (RAS) supplies return targets. It sits between the control/branch-resolution logic and the instruction memory. It exports both the registered PC and the combinational next-PC, so synchronous-read memories can be addressed one cycle early.

## Interface
Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits, aligned).
- INSTR_BYTES, 4, sequential increment; power of 2; defines alignment bits AL = log2(INSTR_BYTES).
- RAS_DEPTH, 4, return-stack entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- redir_valid  in  1  redirect request this cycle.
- redir_kind  in  2  0 = JUMP (branch/jump), 1 = CALL, 2 = RET, 3 = reserved, treated as JUMP.
- redir_target  in  ADDR_W  target for JUMP/CALL; fallback target for RET when the RAS is empty.
- link_addr  in  ADDR_W  return address pushed on CALL.
- pc  out  ADDR_W  registered current PC.
- pc_next  out  ADDR_W  combinational value pc takes at the next edge.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky; set by any push while full.
- ras_unf  out  1  registered one-cycle pulse; RET issued while empty.
- misalign  out  1  registered one-cycle pulse; an accepted redirect target had nonzero low AL bits.

## Operation
- Next-PC priority, highest first:
  - redir_valid: the target, even when stall is asserted (flush beats stall).
  - stall: pc is held.
  - otherwise: pc + INSTR_BYTES, wrapping modulo 2^ADDR_W.
- Target selection:
  - JUMP and reserved kind: redir_target.
  - CALL: redir_target; link_addr is pushed.
  - RET with count > 0: top-of-stack; the entry is popped.
  - RET with count == 0: redir_target; ras_unf pulses; no pop.
- Every target has its low AL bits forced to 0 before loading. misalign pulses if any of those bits were 1 in the pre-masked target.
- RAS is circular:
  - Push writes at tos+1 and increments count, which saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry and sets ras_ovf.
  - Pop decrements tos and count.
  - Pointers wrap modulo RAS_DEPTH.
- The RAS is updated only on a redir_valid cycle; stall alone never alters it.
- There is no simultaneous push and pop, since one kind is accepted per cycle.

## Timing
- Reset (asynchronous assert, synchronous-release use):
  - pc = RESET_VEC, tos = 0, count = 0.
  - ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0, misalign = 0.
  - pc_next = RESET_VEC + INSTR_BYTES.
- Redirect latency is one cycle: a request sampled at edge N gives pc = target after edge N.
- RET reads the stack combinationally in the request cycle, so a RET immediately after a CALL returns the just-pushed link_addr.
- ras_unf and misalign are valid in the cycle after the request and last exactly one cycle.
- ras_ovf stays set until rst_n falls.
- Reset mid-operation discards all RAS contents. No outputs are X after reset.
- Wrap: pc = 2^ADDR_W − INSTR_BYTES with no stall or redirect gives pc = 0 next cycle, with no flag raised.

## Structure
- Package pc_pkg holds:
  - the redir_kind encoding constants (KIND_JUMP, KIND_CALL, KIND_RET);
  - the default INSTR_BYTES;
  - a log2 helper function.
- Sub-module ras_stack (parameters ADDR_W, RAS_DEPTH) owns the storage array, tos/count, the full/empty/ovf logic and the pop-when-empty detection.
- pc_sequencer keeps the PC register, next-PC mux, alignment masking and pulse registers.

## Test plan
- Reset then 4 free-running cycles, defaults → pc = 0x0, 0x4, 0x8, 0xC; ras_empty = 1.
- stall high for 3 cycles with pc = 0x10, then redir_valid JUMP 0x200 while stall is still high → pc holds 0x10 for 3 cycles, then becomes 0x200.
- CALL target 0x100 with link_addr 0x24, then immediately RET → pc = 0x100, then 0x24; ras_empty returns to 1.
- 5 CALLs with link_addr 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 (RAS_DEPTH = 4), then 5 RETs with redir_target 0x300:
  - ras_full and ras_ovf set;
  - RET targets are 0xE0, 0xD0, 0xC0, 0xB0, then 0x300;
  - ras_unf pulses on the 5th RET.
- JUMP to 0x203 → pc = 0x200 and misalign pulses once. Separately, pc = 0xFFFFFFFC free-running → pc = 0x0.
- rst_n asserted mid-cycle while RAS count = 2 → pc = RESET_VEC immediately and ras_empty = 1. A subsequent RET with target 0x40 gives pc = 0x40 and a ras_unf pulse.
